speck_round_ctrl: RTL and testbench

- Encryption datapath and round sequencer for SPECK128/128. Sits directly downstream of key_schedule and consumes its round keys.
- Holds the (x, y) state and applies one round function per round.
- Drives key_schedule through its start/finished handshake to obtain each next round key, and returns the ciphertext after NR_ROUNDS rounds.

---
 rtl/speck_round_ctrl_pkg.sv | 32 +++
 rtl/speck_round_fn.sv | 44 ++++
 rtl/speck_round_ctrl.sv | 146 ++++++++++++++
 tb/tb_speck_round_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/speck_round_ctrl_pkg.sv
// Shared SPECK128/128 constants, sequencer state encoding and word rotates.
// key_schedule imports the same rotate helpers.
package speck_round_ctrl_pkg;

  localparam int unsigned BLOCK_SIZE = 64;
  localparam int unsigned KEY_SIZE   = 128;
  localparam int unsigned NR_ROUNDS  = 32;
  localparam int unsigned ALPHA      = 8;
  localparam int unsigned BETA       = 3;
  localparam int unsigned KS_TIMEOUT = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROUND_X,
    S_ROUND_Y,
    S_KS_REQ,
    S_KS_WAIT,
    S_KS_DROP,
    S_FINISH
  } state_t;

  function automatic logic [BLOCK_SIZE-1:0] ror(input logic [BLOCK_SIZE-1:0] v,
                                                input int unsigned n);
    return (v >> n) | (v << (BLOCK_SIZE - n));
  endfunction

  function automatic logic [BLOCK_SIZE-1:0] rol(input logic [BLOCK_SIZE-1:0] v,
                                                input int unsigned n);
    return (v << n) | (v >> (BLOCK_SIZE - n));
  endfunction

endpackage

// File: rtl/speck_round_fn.sv
// SPECK round datapath: x/y state registers, each half updated on its own strobe
// so y' can be formed from the already-registered x'.
module speck_round_fn
  import speck_round_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic                  i_x_en,
  input  logic                  i_y_en,
  input  logic [BLOCK_SIZE-1:0] i_x_init,
  input  logic [BLOCK_SIZE-1:0] i_y_init,
  input  logic [BLOCK_SIZE-1:0] i_k,
  output logic [BLOCK_SIZE-1:0] o_x,
  output logic [BLOCK_SIZE-1:0] o_y
);

  logic [BLOCK_SIZE-1:0] r_x;
  logic [BLOCK_SIZE-1:0] r_y;
  logic [BLOCK_SIZE-1:0] w_x_next;
  logic [BLOCK_SIZE-1:0] w_y_next;

  always_comb begin
    w_x_next = (ror(r_x, ALPHA) + r_y) ^ i_k;
    w_y_next = rol(r_y, BETA) ^ r_x;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_load) begin
      r_x <= i_x_init;
      r_y <= i_y_init;
    end else begin
      if (i_x_en) r_x <= w_x_next;
      if (i_y_en) r_y <= w_y_next;
    end
  end

  assign o_x = r_x;
  assign o_y = r_y;

endmodule

// File: rtl/speck_round_ctrl.sv
// SPECK128/128 round sequencer: runs NR_ROUNDS rounds and fetches each next
// round key from key_schedule through a start/finished handshake with timeout.
module speck_round_ctrl
  import speck_round_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [KEY_SIZE-1:0]   plaintext,
  input  logic [KEY_SIZE-1:0]   key,
  output logic [KEY_SIZE-1:0]   ciphertext,
  output logic                  done,
  output logic                  busy,
  output logic                  error,
  output logic [KEY_SIZE-1:0]   ks_key,
  output logic [BLOCK_SIZE-1:0] ks_round_ctr,
  output logic                  ks_start,
  input  logic                  ks_finished,
  input  logic [KEY_SIZE-1:0]   ks_out_key
);

  state_t                r_state;
  state_t                w_state_next;
  logic [5:0]            r_round;
  logic [6:0]            r_to_cnt;
  logic [BLOCK_SIZE-1:0] r_l;
  logic [BLOCK_SIZE-1:0] r_k;
  logic [KEY_SIZE-1:0]   r_ct;
  logic [KEY_SIZE-1:0]   r_ks_key;
  logic [BLOCK_SIZE-1:0] r_ks_ctr;
  logic                  r_done;
  logic                  r_busy;
  logic                  r_error;
  logic [BLOCK_SIZE-1:0] w_x;
  logic [BLOCK_SIZE-1:0] w_y;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_expire;
  logic                  w_x_en;
  logic                  w_y_en;
  logic                  w_ks_start;

  assign w_accept = (r_state == S_IDLE) && start && !r_busy;
  assign w_last   = (r_round == 6'(NR_ROUNDS - 1));
  // finished wins over an expiry landing in the same cycle
  assign w_expire = (r_state == S_KS_WAIT) && !ks_finished &&
                    (r_to_cnt == 7'(KS_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_next = S_ROUND_X;
      S_ROUND_X: w_state_next = S_ROUND_Y;
      S_ROUND_Y: w_state_next = w_last ? S_FINISH : S_KS_REQ;
      S_KS_REQ:  w_state_next = S_KS_WAIT;
      S_KS_WAIT: begin
        if (ks_finished)   w_state_next = S_KS_DROP;
        else if (w_expire) w_state_next = S_IDLE;
      end
      S_KS_DROP: w_state_next = S_ROUND_X;
      S_FINISH:  w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // ks_start decodes straight from state so reset drops it asynchronously
  always_comb begin
    w_x_en     = (r_state == S_ROUND_X);
    w_y_en     = (r_state == S_ROUND_Y);
    w_ks_start = (r_state == S_KS_REQ) || (r_state == S_KS_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_round  <= '0;
      r_to_cnt <= '0;
      r_l      <= '0;
      r_k      <= '0;
      r_ct     <= '0;
      r_ks_key <= '0;
      r_ks_ctr <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      if (w_ks_start) r_to_cnt <= r_to_cnt + 7'd1;
      else            r_to_cnt <= '0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_l     <= key[KEY_SIZE-1:BLOCK_SIZE];
          r_k     <= key[BLOCK_SIZE-1:0];
          r_round <= '0;
          r_done  <= 1'b0;
          r_error <= 1'b0;
          r_busy  <= 1'b1;
        end
        S_ROUND_Y: if (!w_last) begin
          r_ks_key <= {r_l, r_k};
          r_ks_ctr <= BLOCK_SIZE'(r_round);
        end
        S_KS_WAIT: begin
          if (ks_finished) begin
            {r_l, r_k} <= ks_out_key;
            r_round    <= r_round + 6'd1;
          end else if (w_expire) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        S_FINISH: begin
          r_ct   <= {w_x, w_y};
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  speck_round_fn u_round_fn (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_accept),
    .i_x_en   (w_x_en),
    .i_y_en   (w_y_en),
    .i_x_init (plaintext[KEY_SIZE-1:BLOCK_SIZE]),
    .i_y_init (plaintext[BLOCK_SIZE-1:0]),
    .i_k      (r_k),
    .o_x      (w_x),
    .o_y      (w_y)
  );

  assign ciphertext   = r_ct;
  assign done         = r_done;
  assign busy         = r_busy;
  assign error        = r_error;
  assign ks_key       = r_ks_key;
  assign ks_round_ctr = r_ks_ctr;
  assign ks_start     = w_ks_start;

endmodule

// File: tb/tb_speck_round_ctrl.sv
// Bench for speck_round_ctrl: behavioural SPECK128/128 model, bench key_schedule
// with fixed/random/never latency, and a per-cycle handshake/result monitor.
module tb_speck_round_ctrl;

  localparam int unsigned NR = 32;
  localparam int unsigned TO = 64;
  localparam logic [127:0] STD_KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] STD_PT  = 128'h6c61766975716520_7469206564616d20;
  localparam logic [127:0] STD_CT  = 128'ha65d985179783265_7860fedf5c570d18;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] plaintext = '0;
  logic [127:0] key = '0;
  logic [127:0] ciphertext;
  logic         done, busy, error;
  logic [127:0] ks_key;
  logic [63:0]  ks_round_ctr;
  logic         ks_start;
  logic         ks_finished;
  logic [127:0] ks_out_key;

  int errors = 0;
  int checks = 0;
  int ks_mode = 0;        // 0 fixed latency, 1 random 1..20, 2 never finishes
  int ks_fixed_lat = 3;

  logic [127:0] exp_rk [NR];
  logic [127:0] exp_ct = '0;
  logic [127:0] last_ct = '0;

  always #5 clk = ~clk;

  speck_round_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .plaintext    (plaintext),
    .key          (key),
    .ciphertext   (ciphertext),
    .done         (done),
    .busy         (busy),
    .error        (error),
    .ks_key       (ks_key),
    .ks_round_ctr (ks_round_ctr),
    .ks_start     (ks_start),
    .ks_finished  (ks_finished),
    .ks_out_key   (ks_out_key)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned s);
    logic [127:0] d;
    d = {v, v};
    return d[s +: 64];
  endfunction

  function automatic logic [127:0] ks_next(input logic [127:0] lk, input logic [63:0] i);
    logic [63:0] l, k;
    l = (lk[63:0] + ror64(lk[127:64], 8)) ^ i;
    k = ror64(lk[63:0], 61) ^ l;
    return {l, k};
  endfunction

  // Whole-cipher reference: round keys and ciphertext for one block
  task automatic model_run(input logic [127:0] pt, input logic [127:0] k);
    logic [63:0] x, y, l, kk;
    x = pt[127:64]; y = pt[63:0]; l = k[127:64]; kk = k[63:0];
    for (int i = 0; i < NR; i++) begin
      exp_rk[i] = {l, kk};
      x = (ror64(x, 8) + y) ^ kk;
      y = ror64(y, 61) ^ x;
      {l, kk} = ks_next({l, kk}, 64'(i));
    end
    exp_ct = {x, y};
  endtask

  // Bench key_schedule
  initial begin
    int unsigned cnt;
    int unsigned lat;
    cnt = 0; lat = 1;
    ks_finished = 1'b0;
    ks_out_key  = '0;
    forever begin
      @(negedge clk);
      if (!ks_start) begin
        ks_finished = 1'b0;
        cnt = 0;
      end else if (!ks_finished && ks_mode != 2) begin
        if (cnt == 0) lat = (ks_mode == 0) ? ks_fixed_lat : $urandom_range(20, 1);
        cnt++;
        if (cnt >= lat) begin
          ks_finished = 1'b1;
          ks_out_key  = ks_next(ks_key, ks_round_ctr);
        end
      end
    end
  end

  // Per-cycle monitor
  initial begin
    bit p_busy, p_ks, p_done, p_err;
    int unsigned cyc, n_cap, n_req, hs_sum, first_ks;
    p_busy = 0; p_ks = 0; p_done = 0; p_err = 0;
    cyc = 0; n_cap = 0; n_req = 0; hs_sum = 0; first_ks = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!rst_n) begin
        p_busy = 0; p_ks = 0; p_done = 0; p_err = 0;
        n_req = 0; hs_sum = 0; last_ct = '0;
      end else begin
        if (busy && !p_busy) begin
          n_cap = cyc; n_req = 0; hs_sum = 0;
        end
        if (ks_start) begin
          hs_sum++;
          if (!p_ks) begin
            if (n_req == 0) first_ks = cyc;
            if (n_req < NR - 1) begin
              chk("ks_round_ctr", 128'(ks_round_ctr), 128'(n_req));
              chk("ks_key", ks_key, exp_rk[n_req]);
            end else begin
              checks++; errors++;
              $display("FAIL ks_req_extra: got request %0d required at most %0d", n_req, NR - 2);
            end
            n_req++;
          end
        end else if (p_ks && !error) begin
          hs_sum++;
        end
        if (done && !p_done) begin
          chk("ciphertext", ciphertext, exp_ct);
          chk("done_busy_err", 128'({busy, error}), 128'(0));
          chk("ks_rises", 128'(n_req), 128'(NR - 1));
          chk("latency", 128'(cyc - n_cap + 1), 128'(2 + 2 * NR + hs_sum));
          last_ct = exp_ct;
        end
        if (error && !p_err) begin
          chk("timeout_cycles", 128'(cyc - first_ks), 128'(TO));
          chk("timeout_flags", 128'({busy, done, ks_start}), 128'(0));
          chk("ct_held", ciphertext, last_ct);
        end
        p_busy = busy; p_ks = ks_start; p_done = done; p_err = error;
      end
    end
  end

  task automatic run_enc(input logic [127:0] pt, input logic [127:0] k,
                         input bit exp_to, input bit dbl);
    bit fin;
    fin = 0;
    model_run(pt, k);
    @(negedge clk);
    plaintext = pt; key = k; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    plaintext = {$urandom, $urandom, $urandom, $urandom};
    key       = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 2; c < 4000 && !fin; c++) begin
      start = (dbl && c == 10);
      @(negedge clk);
      if (done || error) fin = 1;
    end
    start = 1'b0;
    chk(exp_to ? "end_timeout" : "end_done", 128'({done, error}),
        exp_to ? 128'(2'b01) : 128'(2'b10));
  endtask

  initial begin
    bit fin;
    #2;
    chk("rst_ct", ciphertext, '0);
    chk("rst_flags", 128'({done, busy, error, ks_start}), 128'(0));
    chk("rst_ks", {ks_key, ks_round_ctr} != '0, 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    model_run(STD_PT, STD_KEY);
    chk("model_std_ct", exp_ct, STD_CT);

    ks_mode = 0; ks_fixed_lat = 3;
    run_enc(STD_PT, STD_KEY, 0, 0);
    chk("std_ct_literal", ciphertext, STD_CT);

    ks_mode = 1;
    run_enc(STD_PT, STD_KEY, 0, 0);
    run_enc(STD_PT, STD_KEY, 0, 1);
    chk("dbl_start_ct", ciphertext, STD_CT);

    ks_mode = 2;
    run_enc(STD_PT, STD_KEY, 1, 0);
    ks_mode = 1;
    run_enc(STD_PT, STD_KEY, 0, 0);
    chk("after_timeout_ct", ciphertext, STD_CT);

    // Abort inside the round-12 key request
    ks_mode = 0; ks_fixed_lat = 5;
    model_run(STD_PT, STD_KEY);
    @(negedge clk);
    plaintext = STD_PT; key = STD_KEY; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fin = 0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      @(negedge clk);
      if (ks_start && ks_round_ctr == 64'd12) fin = 1;
    end
    chk("reach_round12", 128'(fin), 128'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_flags", 128'({done, busy, error, ks_start}), 128'(0));
    chk("midrst_ct", ciphertext, '0);
    chk("midrst_ks", {ks_key, ks_round_ctr} != '0, 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ks_mode = 1;
    run_enc(STD_PT, STD_KEY, 0, 0);

    run_enc('0, '0, 0, 0);
    for (int r = 0; r < 5; r++)
      run_enc({$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
